// File: rtl/elevador_pkg.sv
// Shared types and constants for the N-floor elevator controller:
// FSM state encoding and active-low 7-segment glyphs {a,b,c,d,e,f,g}.
package elevador_pkg;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    SUBIENDO = 2'd1,
    BAJANDO  = 2'd2,
    PUERTA   = 2'd3
  } estado_e;

  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/elevador_n_dec_7seg.sv
// Active-low 7-segment decoder for floor numbers 1..9; anything else is blank.
module dec_7seg (
  input  logic [3:0] valor,
  output logic [6:0] seg
);
  import elevador_pkg::*;

  // Glyph lookup
  always_comb begin
    seg = SEG_BLANK;
    case (valor)
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/elevador_n.sv
// N-floor SCAN elevator controller: latched calls, timed travel and door dwell,
// registered motor/door enables and a 1-based floor display.
module elevador_n #(
  parameter  int NUM_PISOS  = 4,
  parameter  int TRAVEL_CYC = 8,
  parameter  int DOOR_CYC   = 4,
  localparam int PW         = $clog2(NUM_PISOS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PISOS-1:0] llamada,
  output logic                 motorsubir,
  output logic                 motorbajar,
  output logic                 puerta_abierta,
  output logic [PW-1:0]        piso_actual,
  output logic [NUM_PISOS-1:0] pendientes,
  output logic [6:0]           display
);
  import elevador_pkg::*;

  localparam int TW = (TRAVEL_CYC > 1) ? $clog2(TRAVEL_CYC) : 1;
  localparam int DW = (DOOR_CYC > 1) ? $clog2(DOOR_CYC) : 1;
  localparam logic [TW-1:0] T_FIN  = TW'(TRAVEL_CYC - 1);
  localparam logic [DW-1:0] D_FIN  = DW'(DOOR_CYC - 1);
  localparam logic [PW-1:0] P_TOPE = PW'(NUM_PISOS - 1);

  // Out-of-range indices yield all zeros, so neighbour lookups at the ends are safe.
  function automatic logic [NUM_PISOS-1:0] onehot(input int idx);
    logic [NUM_PISOS-1:0] o;
    for (int i = 0; i < NUM_PISOS; i++) o[i] = (i == idx);
    return o;
  endfunction

  estado_e              estado_r;
  logic [PW-1:0]        piso_r;
  logic [NUM_PISOS-1:0] pend_r;
  logic                 dir_up_r;
  logic [TW-1:0]        tcnt_r;
  logic [DW-1:0]        dcnt_r;
  logic                 subir_r, bajar_r, puerta_r;

  logic [NUM_PISOS-1:0] pl_s, arriba_s, abajo_s, clr_s;
  logic                 aqui_s, aqui_pl_s, llega_arr_s, llega_ab_s;
  logic [3:0]           valor_s;

  // Request masks, arrival hits and the clear vector for the floor being served
  always_comb begin
    pl_s        = pend_r | llamada;
    aqui_s      = |(pend_r & onehot(int'(piso_r)));
    aqui_pl_s   = |(pl_s & onehot(int'(piso_r)));
    llega_arr_s = |(pl_s & onehot(int'(piso_r) + 1));
    llega_ab_s  = |(pl_s & onehot(int'(piso_r) - 1));
    arriba_s    = '0;
    abajo_s     = '0;
    for (int i = 0; i < NUM_PISOS; i++) begin
      arriba_s[i] = pend_r[i] & (i > int'(piso_r));
      abajo_s[i]  = pend_r[i] & (i < int'(piso_r));
    end
    clr_s = '0;
    case (estado_r)
      REPOSO: begin
        if (aqui_s) clr_s = onehot(int'(piso_r));
        else        clr_s = '0;
      end
      SUBIENDO: begin
        if (tcnt_r == T_FIN && piso_r != P_TOPE && llega_arr_s) clr_s = onehot(int'(piso_r) + 1);
        else                                                    clr_s = '0;
      end
      BAJANDO: begin
        if (tcnt_r == T_FIN && piso_r != '0 && llega_ab_s) clr_s = onehot(int'(piso_r) - 1);
        else                                               clr_s = '0;
      end
      PUERTA: begin
        if (aqui_pl_s) clr_s = onehot(int'(piso_r));
        else           clr_s = '0;
      end
      default: clr_s = '0;
    endcase
  end

  // Controller FSM, request register, counters and registered enables
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_r <= REPOSO;
      piso_r   <= '0;
      pend_r   <= '0;
      dir_up_r <= 1'b1;
      tcnt_r   <= '0;
      dcnt_r   <= '0;
      subir_r  <= 1'b0;
      bajar_r  <= 1'b0;
      puerta_r <= 1'b0;
    end else begin
      pend_r <= pl_s & ~clr_s;
      case (estado_r)
        REPOSO: begin
          tcnt_r <= '0;
          dcnt_r <= '0;
          if (aqui_s) begin
            estado_r <= PUERTA;
            puerta_r <= 1'b1;
          end else if (|arriba_s && (dir_up_r || !(|abajo_s))) begin
            estado_r <= SUBIENDO;
            dir_up_r <= 1'b1;
            subir_r  <= 1'b1;
          end else if (|abajo_s) begin
            estado_r <= BAJANDO;
            dir_up_r <= 1'b0;
            bajar_r  <= 1'b1;
          end else begin
            estado_r <= REPOSO;
          end
        end
        SUBIENDO: begin
          if (tcnt_r == T_FIN) begin
            tcnt_r <= '0;
            if (piso_r != P_TOPE) begin
              piso_r <= piso_r + PW'(1);
              if (llega_arr_s) begin
                estado_r <= PUERTA;
                subir_r  <= 1'b0;
                puerta_r <= 1'b1;
              end else begin
                estado_r <= SUBIENDO;
              end
            end else begin
              estado_r <= REPOSO;
              subir_r  <= 1'b0;
            end
          end else begin
            tcnt_r <= tcnt_r + TW'(1);
          end
        end
        BAJANDO: begin
          if (tcnt_r == T_FIN) begin
            tcnt_r <= '0;
            if (piso_r != '0) begin
              piso_r <= piso_r - PW'(1);
              if (llega_ab_s) begin
                estado_r <= PUERTA;
                bajar_r  <= 1'b0;
                puerta_r <= 1'b1;
              end else begin
                estado_r <= BAJANDO;
              end
            end else begin
              estado_r <= REPOSO;
              bajar_r  <= 1'b0;
            end
          end else begin
            tcnt_r <= tcnt_r + DW'(0) + TW'(1);
          end
        end
        PUERTA: begin
          // A re-call for this floor holds the door open for a fresh dwell
          if (aqui_pl_s) begin
            dcnt_r <= '0;
          end else if (dcnt_r == D_FIN) begin
            dcnt_r   <= '0;
            estado_r <= REPOSO;
            puerta_r <= 1'b0;
          end else begin
            dcnt_r <= dcnt_r + DW'(1);
          end
        end
        default: begin
          estado_r <= REPOSO;
          subir_r  <= 1'b0;
          bajar_r  <= 1'b0;
          puerta_r <= 1'b0;
        end
      endcase
    end
  end

  assign valor_s = 4'(piso_r) + 4'd1;

  dec_7seg u_dec (
    .valor (valor_s),
    .seg   (display)
  );

  assign motorsubir     = subir_r;
  assign motorbajar     = bajar_r;
  assign puerta_abierta = puerta_r;
  assign piso_actual    = piso_r;
  assign pendientes     = pend_r;

endmodule
